// File: rtl/neuro_pkg.sv
// Shared constants and types for the Hopfield learning/recall datapath.
// Bit-order convention: a 5x5 pattern is packed row-major, so pixel (row, col)
// is neuron row*5+col, bit 0 is the top-left pixel. The recall engine and the
// LED scan use the same ordering.
package neuro_pkg;

  localparam int unsigned N   = 25;      // neuron count
  localparam int unsigned NN  = N * N;   // weight store depth
  localparam int unsigned WW  = 4;       // signed weight width
  localparam int unsigned AW  = 10;      // weight address width, 2**AW >= NN
  localparam int unsigned PCW = 4;       // stored-pattern counter width
  localparam int unsigned IW  = 5;       // neuron index width

  // Symmetric clamp range, so negation of a stored weight never overflows
  localparam int W_MAX = 2 ** (WW - 1) - 1;
  localparam int W_MIN = -W_MAX;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LEARN = 2'd2
  } state_t;

endpackage

// File: rtl/hebb_weight_mem.sv
// N*N x WW weight register array: one synchronous write port, a combinational
// read-modify-write port and a combinational recall port. Reset clears all
// entries. Out-of-range reads return 0; out-of-range writes are dropped.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   we, waddr, wdata  write port
//   raddr_a/rdata_a_c RMW read port (used by the trainer sweep)
//   raddr_b/rdata_b_c recall read port
module hebb_weight_mem
  import neuro_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [WW-1:0] rdata_a_c,
  input  logic [AW-1:0] raddr_b,
  output logic [WW-1:0] rdata_b_c
);

  logic [WW-1:0] mem [NN];

  // Storage with full clear on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NN; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr < AW'(NN))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = (raddr_a < AW'(NN)) ? mem[raddr_a] : '0;
  assign rdata_b_c = (raddr_b < AW'(NN)) ? mem[raddr_b] : '0;

endmodule

// File: rtl/hebb_trainer.sv
// Hebbian trainer for the 25-neuron Hopfield recall engine. Each accepted 5x5
// pattern is folded into the weight store one weight per clock:
//   w[k][m] = clamp(w[k][m] + ((p[k]==p[m]) ? +1 : -1)), clamp to +/-W_MAX.
// A clear sweeps zeros through the whole store with the same timing.
// Build option: define ZERO_DIAG_EN to force the diagonal w[k][k] to 0 in both
// LEARN and CLEAR (no self-feedback in recall); otherwise the diagonal
// accumulates like any other weight.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   clr                  1-cycle pulse: zero weights and counters (IDLE only)
//   pat_valid/pat_ready  pattern handshake, pat sampled in the handshake cycle
//   pat                  N-bit pattern, bit i = neuron i
//   busy                 sweep in progress, rd_data not coherent
//   pat_count            patterns learned since last clear (saturating)
//   sat                  sticky: a weight update was clamped
//   rd_addr/rd_data      recall read port, address k*N+m
module hebb_trainer
  import neuro_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           pat_valid,
  output logic           pat_ready,
  input  logic [N-1:0]   pat,
  output logic           busy,
  output logic [PCW-1:0] pat_count,
  output logic           sat,
  input  logic [AW-1:0]  rd_addr,
  output logic [WW-1:0]  rd_data
);

  localparam logic signed [WW:0] MAX_X = (WW + 1)'(W_MAX);
  localparam logic signed [WW:0] MIN_X = (WW + 1)'(W_MIN);
  localparam logic [IW-1:0]      LAST  = IW'(N - 1);

  state_t          state, state_d;
  logic [IW-1:0]   k, m;
  logic [AW-1:0]   addr;
  logic [N-1:0]    pat_q;

  logic            last_c;
  logic            accept_c;
  logic            start_clr_c;
  logic            we_c;
  logic            zero_c;
  logic            clamp_c;
  logic            sat_set_c;
  logic [WW-1:0]   cur_c;
  logic [WW-1:0]   upd_c;
  logic [WW-1:0]   wdata_c;
  logic signed [WW:0] delta_c;
  logic signed [WW:0] sum_c;

  assign last_c = (k == LAST) && (m == LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and handshake outputs; clr wins over pat_valid in IDLE
  always_comb begin
    state_d     = state;
    pat_ready   = 1'b0;
    busy        = 1'b1;
    accept_c    = 1'b0;
    start_clr_c = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        pat_ready = ~clr;
        if (clr) begin
          start_clr_c = 1'b1;
          state_d     = ST_CLEAR;
        end else if (pat_valid) begin
          accept_c = 1'b1;
          state_d  = ST_LEARN;
        end
      end
      ST_CLEAR, ST_LEARN: begin
        if (last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating +/-1 update computed one bit wider than the stored weight
  always_comb begin
    delta_c = (pat_q[k] == pat_q[m]) ? (WW + 1)'(1) : '1;
    sum_c   = $signed({cur_c[WW-1], cur_c}) + delta_c;
    clamp_c = 1'b0;
    upd_c   = sum_c[WW-1:0];
    if (sum_c > MAX_X) begin
      clamp_c = 1'b1;
      upd_c   = WW'(MAX_X);
    end else if (sum_c < MIN_X) begin
      clamp_c = 1'b1;
      upd_c   = WW'(MIN_X);
    end
  end

  // Write selection: zeros during CLEAR (and on the diagonal when enabled)
  always_comb begin
`ifdef ZERO_DIAG_EN
    zero_c = (state == ST_CLEAR) || (k == m);
`else
    zero_c = (state == ST_CLEAR);
`endif
    we_c      = (state != ST_IDLE);
    wdata_c   = zero_c ? '0 : upd_c;
    sat_set_c = (state == ST_LEARN) && !zero_c && clamp_c;
  end

  // Index walk with a running address counter (k*N+m without a multiplier)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k     <= '0;
      m     <= '0;
      addr  <= '0;
      pat_q <= '0;
    end else begin
      if (accept_c) begin
        pat_q <= pat;
      end
      if ((state == ST_IDLE) || last_c) begin
        k    <= '0;
        m    <= '0;
        addr <= '0;
      end else begin
        addr <= addr + AW'(1);
        if (m == LAST) begin
          m <= '0;
          k <= k + IW'(1);
        end else begin
          m <= m + IW'(1);
        end
      end
    end
  end

  // Pattern counter and sticky clamp flag, both cleared when a clear starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_count <= '0;
      sat       <= 1'b0;
    end else if (start_clr_c) begin
      pat_count <= '0;
      sat       <= 1'b0;
    end else begin
      if (sat_set_c) begin
        sat <= 1'b1;
      end
      if ((state == ST_LEARN) && last_c && (pat_count != '1)) begin
        pat_count <= pat_count + PCW'(1);
      end
    end
  end

  hebb_weight_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (we_c),
    .waddr     (addr),
    .wdata     (wdata_c),
    .raddr_a   (addr),
    .rdata_a_c (cur_c),
    .raddr_b   (rd_addr),
    .rdata_b_c (rd_data)
  );

endmodule
